// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle controller for the 16-bit lab CPU: sequences register file, A/B/C,
// status and ALU input muxes for one instruction per accepted start pulse.
module cpu_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       write,
  output logic       err
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_COMPUTE, S_WRITE_REG
  } state_t;

  state_t     state, nxt;
  logic [2:0] opc_q, opc_d;
  logic [1:0] op_q, op_d;

  function automatic logic is_mov_imm(input logic [2:0] oc, input logic [1:0] o);
    return (oc == 3'b110) && (o == 2'b10);
  endfunction

  function automatic logic is_alu_ab(input logic [2:0] oc, input logic [1:0] o);
    return (oc == 3'b101) && (o != 2'b11);
  endfunction

  // MOV reg and MVN only need B; the ALU A input is forced to zero for them.
  function automatic logic is_b_only(input logic [2:0] oc, input logic [1:0] o);
    return ((oc == 3'b110) && (o == 2'b00)) || ((oc == 3'b101) && (o == 2'b11));
  endfunction

  function automatic logic is_cmp(input logic [2:0] oc, input logic [1:0] o);
    return (oc == 3'b101) && (o == 2'b01);
  endfunction

  always_comb begin
    nxt   = state;
    opc_d = opc_q;
    op_d  = op_q;
    case (state)
      S_WAIT: begin
        if (s) begin
          nxt   = S_DECODE;
          opc_d = opcode;
          op_d  = op;
        end
      end
      S_DECODE: begin
        if (is_mov_imm(opc_q, op_q))     nxt = S_WRITE_IMM;
        else if (is_alu_ab(opc_q, op_q)) nxt = S_GET_A;
        else if (is_b_only(opc_q, op_q)) nxt = S_GET_B;
        else                             nxt = S_WAIT;
      end
      S_WRITE_IMM: nxt = S_WAIT;
      S_GET_A:     nxt = S_GET_B;
      S_GET_B:     nxt = S_COMPUTE;
      S_COMPUTE:   nxt = is_cmp(opc_q, op_q) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: nxt = S_WAIT;
      default:     nxt = S_WAIT;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      w     <= 1'b1;
      nsel  <= 2'b00;
      vsel  <= 2'b00;
      loada <= 1'b0;
      loadb <= 1'b0;
      loadc <= 1'b0;
      loads <= 1'b0;
      asel  <= 1'b0;
      write <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      opc_q <= opc_d;
      op_q  <= op_d;
      w     <= 1'b0;
      nsel  <= 2'b00;
      vsel  <= 2'b00;
      loada <= 1'b0;
      loadb <= 1'b0;
      loadc <= 1'b0;
      loads <= 1'b0;
      asel  <= 1'b0;
      write <= 1'b0;
      err   <= 1'b0;
      case (nxt)
        S_WAIT:      w <= 1'b1;
        S_DECODE:    err <= !(is_mov_imm(opc_d, op_d) || is_alu_ab(opc_d, op_d) ||
                              is_b_only(opc_d, op_d));
        S_WRITE_IMM: begin
          vsel  <= 2'b10;
          write <= 1'b1;
        end
        S_GET_A:     loada <= 1'b1;
        S_GET_B: begin
          nsel  <= 2'b10;
          loadb <= 1'b1;
        end
        S_COMPUTE: begin
          asel  <= is_b_only(opc_d, op_d);
          loads <= is_cmp(opc_d, op_d);
          loadc <= !is_cmp(opc_d, op_d);
        end
        S_WRITE_REG: begin
          nsel  <= 2'b01;
          write <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Table-driven bench for cpu_ctrl_fsm; a sequence model fills a scoreboard of
// expected per-cycle control words that is drained as the DUT steps.
module tb_cpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset, s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w, loada, loadb, loadc, loads, asel, write, err;
  logic [1:0] nsel, vsel;

  int tests = 0;
  int fails = 0;
  logic [11:0] sb[$];

  cpu_ctrl_fsm dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .write(write), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] opc;
    logic [1:0] op;
    int         lat;
    int         nw;
    logic       scramble;
  } vec_t;

  vec_t tv[9];

  // Control word: {w, nsel, vsel, loada, loadb, loadc, loads, asel, write, err}
  function automatic logic [11:0] pk(input logic w_, input logic [1:0] ns, input logic [1:0] vs,
                                     input logic la, input logic lb, input logic lc,
                                     input logic ls, input logic as, input logic wr,
                                     input logic er);
    return {w_, ns, vs, la, lb, lc, ls, as, wr, er};
  endfunction

  function automatic logic [11:0] dut_word();
    return {w, nsel, vsel, loada, loadb, loadc, loads, asel, write, err};
  endfunction

  localparam logic [11:0] P_WAIT = 12'b1_00_00_0000_000;

  task automatic push_seq(input logic [2:0] oc, input logic [1:0] o);
    logic legal_movi, legal_ab, legal_b;
    legal_movi = (oc == 3'b110 && o == 2'b10);
    legal_ab   = (oc == 3'b101 && o != 2'b11);
    legal_b    = (oc == 3'b110 && o == 2'b00) || (oc == 3'b101 && o == 2'b11);
    sb.push_back(pk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, !(legal_movi || legal_ab || legal_b)));
    if (legal_movi) begin
      sb.push_back(pk(0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 1, 0));
    end else if (legal_ab) begin
      sb.push_back(pk(0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0));
      sb.push_back(pk(0, 2'b10, 2'b00, 0, 1, 0, 0, 0, 0, 0));
      if (o == 2'b01) begin
        sb.push_back(pk(0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0));
      end else begin
        sb.push_back(pk(0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0));
        sb.push_back(pk(0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1, 0));
      end
    end else if (legal_b) begin
      sb.push_back(pk(0, 2'b10, 2'b00, 0, 1, 0, 0, 0, 0, 0));
      sb.push_back(pk(0, 2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 0));
      sb.push_back(pk(0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1, 0));
    end
    sb.push_back(P_WAIT);
    sb.push_back(P_WAIT);
  endtask

  task automatic chk_word(input string name, input logic [11:0] exp);
    tests++;
    if (dut_word() !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, dut_word(), exp);
    end
  endtask

  task automatic chk_pop(input string name);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, got %b", name, dut_word());
    end else begin
      chk_word(name, sb.pop_front());
    end
  endtask

  // Drives one instruction (s is raised here and accepted on the next edge).
  task automatic run_instr(input vec_t v, input string name);
    logic wv[16];
    int   n, idx, nwr;
    sb.delete();
    opcode = v.opc;
    op     = v.op;
    s      = 1'b1;
    push_seq(v.opc, v.op);
    n   = sb.size();
    nwr = 0;
    @(posedge clk);
    #1;
    s = 1'b0;
    if (v.scramble) begin
      opcode = 3'b000;
      op     = 2'b11;
    end
    for (idx = 0; idx < n; idx++) begin
      if (idx > 0) begin
        @(posedge clk);
        #1;
      end
      if (idx < 16) wv[idx] = w;
      if (write) nwr++;
      chk_pop($sformatf("%s cyc%0d", name, idx));
    end
    tests++;
    if (v.lat >= n || wv[v.lat] !== 1'b1) begin
      fails++;
      $display("FAIL %s latency: w not 1 at edge %0d after accept", name, v.lat);
    end
    tests++;
    if (nwr != v.nw) begin
      fails++;
      $display("FAIL %s writes: got %0d, expected %0d", name, nwr, v.nw);
    end
  endtask

  initial begin
    tv[0] = '{3'b110, 2'b10, 2, 1, 1'b0};  // MOV imm
    tv[1] = '{3'b101, 2'b00, 5, 1, 1'b1};  // ADD, decoder changes after accept
    tv[2] = '{3'b101, 2'b10, 5, 1, 1'b0};  // AND
    tv[3] = '{3'b101, 2'b01, 4, 0, 1'b1};  // CMP
    tv[4] = '{3'b101, 2'b11, 4, 1, 1'b0};  // MVN
    tv[5] = '{3'b110, 2'b00, 4, 1, 1'b1};  // MOV reg
    tv[6] = '{3'b111, 2'b00, 2, 0, 1'b0};  // illegal opcode
    tv[7] = '{3'b110, 2'b01, 2, 0, 1'b0};  // illegal op
    tv[8] = '{3'b000, 2'b00, 2, 0, 1'b0};  // illegal opcode

    reset  = 1'b1;
    s      = 1'b1;
    opcode = 3'b110;
    op     = 2'b10;
    @(posedge clk);
    #1;
    chk_word("reset s=1 a", P_WAIT);
    @(posedge clk);
    #1;
    chk_word("reset s=1 b", P_WAIT);
    reset = 1'b0;
    run_instr(tv[0], "post-reset movi");

    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      run_instr(tv[i], $sformatf("vec%0d", i));
    end

    // Reset arriving while ADD sits in COMPUTE.
    @(posedge clk);
    #1;
    opcode = 3'b101;
    op     = 2'b00;
    s      = 1'b1;
    @(posedge clk);
    #1;
    s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_word("abort compute", pk(0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_word("abort reset edge", P_WAIT);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_word($sformatf("abort idle%0d", i), P_WAIT);
    end

    // s held high: back-to-back MOV imm with one WAIT cycle between them.
    sb.delete();
    opcode = 3'b110;
    op     = 2'b10;
    s      = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(pk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(pk(0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 1, 0));
      sb.push_back(P_WAIT);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) s = 1'b0;
      chk_pop($sformatf("b2b cyc%0d", i));
    end
    @(posedge clk);
    #1;
    chk_word("b2b stop", P_WAIT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
